// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use stalls, branch flushes
// and a MEM-stage wait-state FSM. Optional stall counter behind `HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReadE,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic                 BusErr,
  output logic [CNT_WIDTH-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(WAIT_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lw_stall, freeze, branch, lw_hold;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  assign lw_stall = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

  // The timeout cycle releases the freeze even though the slave is still not ready.
  assign freeze  = MemReqM && !MemReadyM && (state != TIMEOUT);
  assign branch  = !freeze && PCSrcE;
  assign lw_hold = !freeze && !PCSrcE && lw_stall;

  assign StallF = reset & (freeze | lw_hold);
  assign StallD = reset & (freeze | lw_hold);
  assign StallE = reset & freeze;
  assign StallM = reset & freeze;
  assign FlushD = reset & branch;
  assign FlushE = reset & (branch | lw_hold);
  assign FlushW = reset & freeze;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      BusErr   <= 1'b0;
    end else begin
      BusErr <= 1'b0;
      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!MemReqM || MemReadyM) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == TO_LIMIT) begin
              state  <= TIMEOUT;
              BusErr <= 1'b1;
            end
          end
        end
        TIMEOUT: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                stall_cnt <= '0;
    else if (StallF && stall_cnt != {CNT_WIDTH{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (WAIT_TIMEOUT=4); inputs driven at negedge, outputs checked 1ns later.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, MemReadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, BusErr;
  logic [15:0] StallCount;
  logic [6:0]  ctl;

  int compared = 0;
  int mismatched = 0;
  int stalls = 0;

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_LW     = 7'b1100010;
  localparam logic [6:0] C_BRANCH = 7'b0000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .BusErr(BusErr), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0;
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    MemReadE = 1'b1; RdE = 5'd3; Rs1D = 5'd3; MemReqM = 1'b1;
    #1;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE); end
    compared++;
    if (BusErr !== 1'b0) begin mismatched++; $display("FAIL reset_buserr got %b want 0", BusErr); end
    compared++;
    if (StallCount !== 16'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", StallCount); end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_IDLE); end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd0;
    #1;
    compared++;
    if (ForwardAE !== 2'b10) begin mismatched++; $display("FAIL fwd_a_mem got %b want 10", ForwardAE); end
    compared++;
    if (ForwardBE !== 2'b00) begin mismatched++; $display("FAIL fwd_b_x0 got %b want 00", ForwardBE); end
    RdM = 5'd0;
    #1;
    compared++;
    if (ForwardAE !== 2'b01) begin mismatched++; $display("FAIL fwd_a_wb got %b want 01", ForwardAE); end
    RdM = 5'd9; Rs2E = 5'd9;
    #1;
    compared++;
    if (ForwardBE !== 2'b10) begin mismatched++; $display("FAIL fwd_b_mem got %b want 10", ForwardBE); end
    RegWriteM = 1'b0; RdW = 5'd9;
    #1;
    compared++;
    if (ForwardBE !== 2'b01) begin mismatched++; $display("FAIL fwd_b_wb got %b want 01", ForwardBE); end
    compared++;
    if (ForwardAE !== 2'b00) begin mismatched++; $display("FAIL fwd_a_none got %b want 00", ForwardAE); end
    RegWriteW = 1'b0;
    #1;
    compared++;
    if (ForwardBE !== 2'b00) begin mismatched++; $display("FAIL fwd_b_nowrite got %b want 00", ForwardBE); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    compared++;
    if (ctl !== C_LW) begin mismatched++; $display("FAIL lw_stall got %b want %b", ctl, C_LW); end
    stalls++;
    @(negedge clk);
    MemReadE = 1'b0;
    #1;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL lw_clear got %b want %b", ctl, C_IDLE); end
    compared++;
    if (StallCount !== (PERF ? 16'(stalls) : 16'd0))
      begin mismatched++; $display("FAIL lw_count got %0d want %0d", StallCount, PERF ? stalls : 0); end
    RdE = 5'd0; MemReadE = 1'b1; Rs1D = 5'd0;
    #1;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL lw_x0 got %b want %b", ctl, C_IDLE); end
    clear_inputs();
  endtask

  task automatic test_branch_vs_lw();
    @(negedge clk);
    MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    #1;
    compared++;
    if (ctl !== C_BRANCH) begin mismatched++; $display("FAIL branch_over_lw got %b want %b", ctl, C_BRANCH); end
    @(negedge clk);
    clear_inputs();
    #1;
    compared++;
    if (StallCount !== (PERF ? 16'(stalls) : 16'd0))
      begin mismatched++; $display("FAIL branch_count got %0d want %0d", StallCount, PERF ? stalls : 0); end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = (i == 1); MemReadE = 1'b1; RdE = 5'd4; Rs1D = 5'd4;
      #1;
      compared++;
      if (ctl !== C_FREEZE) begin mismatched++; $display("FAIL wait_freeze[%0d] got %b want %b", i, ctl, C_FREEZE); end
      compared++;
      if (BusErr !== 1'b0) begin mismatched++; $display("FAIL wait_buserr[%0d] got %b want 0", i, BusErr); end
      stalls++;
    end
    @(negedge clk);
    clear_inputs();
    MemReqM = 1'b1; MemReadyM = 1'b1;
    #1;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL wait_release got %b want %b", ctl, C_IDLE); end
    @(negedge clk);
    clear_inputs();
    #1;
    compared++;
    if (BusErr !== 1'b0) begin mismatched++; $display("FAIL wait_no_buserr got %b want 0", BusErr); end
    compared++;
    if (StallCount !== (PERF ? 16'(stalls) : 16'd0))
      begin mismatched++; $display("FAIL wait_count got %0d want %0d", StallCount, PERF ? stalls : 0); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = 1'b0;
      #1;
      compared++;
      if (ctl !== C_FREEZE) begin mismatched++; $display("FAIL to_freeze[%0d] got %b want %b", i, ctl, C_FREEZE); end
      compared++;
      if (BusErr !== 1'b0) begin mismatched++; $display("FAIL to_early_buserr[%0d] got %b want 0", i, BusErr); end
      stalls++;
    end
    @(negedge clk);
    #1;
    compared++;
    if (BusErr !== 1'b1) begin mismatched++; $display("FAIL to_buserr got %b want 1", BusErr); end
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL to_release got %b want %b", ctl, C_IDLE); end
    @(negedge clk);
    clear_inputs();
    #1;
    compared++;
    if (BusErr !== 1'b0) begin mismatched++; $display("FAIL to_pulse_end got %b want 0", BusErr); end
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL to_run got %b want %b", ctl, C_IDLE); end
    compared++;
    if (StallCount !== (PERF ? 16'(stalls) : 16'd0))
      begin mismatched++; $display("FAIL to_count got %0d want %0d", StallCount, PERF ? stalls : 0); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    stalls = 0;
    compared++;
    if (ctl !== C_IDLE) begin mismatched++; $display("FAIL arst_ctl got %b want %b", ctl, C_IDLE); end
    compared++;
    if (StallCount !== 16'd0) begin mismatched++; $display("FAIL arst_count got %0d want 0", StallCount); end
    compared++;
    if (BusErr !== 1'b0) begin mismatched++; $display("FAIL arst_buserr got %b want 0", BusErr); end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    // From RUN a fresh wait must freeze for the full four cycles before the timeout pulse.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemReqM = 1'b1; MemReadyM = 1'b0;
      #1;
      compared++;
      if (ctl !== C_FREEZE || BusErr !== 1'b0)
        begin mismatched++; $display("FAIL arst_resume[%0d] got ctl=%b err=%b want ctl=%b err=0", i, ctl, BusErr, C_FREEZE); end
      stalls++;
    end
    @(negedge clk);
    #1;
    compared++;
    if (BusErr !== 1'b1) begin mismatched++; $display("FAIL arst_timeout got %b want 1", BusErr); end
    @(negedge clk);
    clear_inputs();
    #1;
    compared++;
    if (StallCount !== (PERF ? 16'(stalls) : 16'd0))
      begin mismatched++; $display("FAIL arst_final_count got %0d want %0d", StallCount, PERF ? stalls : 0); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_lw();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates forwarding selects, load-use stalls and branch/jump flushes.
- Runs a wait-state FSM that freezes the pipeline while a MEM-stage peripheral access (RAM/UART/GPIO) is not ready, with timeout and bus-error reporting.
- Sits beside the datapath; drives the pipeline-register enables and clears.

Parameters:
- WAIT_TIMEOUT, 16, max consecutive not-ready cycles before a forced release (2..255)
- CNT_WIDTH, 16, width of stall performance counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Rs1D, Rs2D  in  5  source registers in ID
- Rs1E, Rs2E  in  5  source registers in EX
- RdE, RdM, RdW  in  5  destination registers in EX/MEM/WB
- RegWriteM, RegWriteW  in  1  register write enable in MEM/WB
- MemReadE  in  1  EX instruction is a load
- PCSrcE  in  1  branch taken or jump resolved in EX
- MemReqM  in  1  MEM stage issues a memory/peripheral access
- MemReadyM  in  1  addressed slave ready this cycle
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW
- StallF, StallD, StallE, StallM  out  1  hold the corresponding register (1 = hold)
- FlushD, FlushE, FlushW  out  1  synchronous clear of IF/ID, ID/EX, MEM/WB
- BusErr  out  1  one-cycle pulse on wait timeout
- StallCount  out  CNT_WIDTH  stall-cycle counter

Behaviour:
- Reset (reset=0, async): state=RUN, wait counter=0, BusErr=0, StallCount=0. All stall and flush outputs are 0 while in reset. Forward selects stay combinational.
- Forwarding (combinational, every state): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. ForwardBE uses Rs2E with the same rules. MEM has priority over WB.
- Load-use hazard lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, MEM_WAIT, TIMEOUT.
- RUN:
  - If MemReqM && !MemReadyM: go to MEM_WAIT, wait counter=1, and assert the freeze set this same cycle (combinational on inputs).
  - Else if PCSrcE: FlushD=1, FlushE=1, no stall. A branch overrides lwStall because the ID instruction is discarded.
  - Else if lwStall: StallF=1, StallD=1, FlushE=1 for exactly one cycle; the hazard clears naturally when the load reaches MEM.
- Freeze set: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. PCSrcE and lwStall are ignored while frozen.
- MEM_WAIT:
  - Freeze set asserted.
  - On MemReadyM=1: deassert freeze that cycle, return to RUN, clear the counter.
  - Otherwise increment the counter; when it reaches WAIT_TIMEOUT, go to TIMEOUT.
  - If MemReqM drops while waiting (not legal but tolerated): return to RUN, counter=0.
- TIMEOUT:
  - Lasts one cycle; BusErr=1.
  - Freeze released: the MEM instruction completes with undefined read data and does not retry.
  - Next state is RUN, counter=0.
- StallCount: increments by 1 in any cycle where StallF=1, saturates at all-ones, never wraps, cleared only by reset.
- Reset asserted mid-wait: immediate return to RUN, no BusErr.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: StallCount is implemented as described above.
- Undefined: no counter register; StallCount is tied to 0.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Repeat with RdM=0 -> ForwardAE=01.
- Load-use: MemReadE=1, RdE=7, Rs2D=7, no MEM request -> StallF=StallD=FlushE=1 for one cycle. Next cycle with MemReadE=0 -> all 0. StallCount +1.
- Branch vs load-use: PCSrcE=1 together with lwStall conditions -> FlushD=FlushE=1, StallF=0.
- Peripheral wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> freeze set for 3 cycles, released in the 4th cycle. BusErr stays 0. StallCount +3.
- Timeout: WAIT_TIMEOUT=4, MemReadyM held 0 -> freeze for 4 cycles, BusErr=1 for one cycle, then RUN with stalls 0.
- Async reset: assert reset=0 mid-MEM_WAIT between clock edges -> all stalls and flushes 0 immediately, StallCount=0. After release, FSM resumes in RUN.
